// File: rtl/sm_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sm_adder_arbiter
// Description : Shares one registered sign-magnitude adder among NUM_REQ
//               requesters. Round-robin grant, operands sequenced through the
//               adder's one-cycle registered path, equal-magnitude/opposite-
//               sign and negative-zero results forced to +0, result returned
//               with the winner's ID under valid/ready.
//               Build option: define SM_ARB_FIXED_PRIO_EN for fixed priority
//               (lowest index wins, no round-robin pointer).
// Revision    : 1.0 - initial release
// ============================================================================
module sm_adder_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [DATA_WIDTH-1:0]         adder_a,
    output logic [DATA_WIDTH-1:0]         adder_b,
    input  logic [DATA_WIDTH:0]           adder_sum,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH:0]           rsp_sum,
    output logic [ID_W-1:0]               rsp_id,
    output logic                          busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ID_W-1:0]         w_grant;
    logic                    w_grant_vld;
    logic                    w_take;
    logic [NUM_REQ-1:0]      w_req_ready;
    logic [DATA_WIDTH-1:0]   r_op_a;
    logic [DATA_WIDTH-1:0]   r_op_b;
    logic [ID_W-1:0]         r_rsp_id;
    logic [DATA_WIDTH:0]     r_rsp_sum;
    logic [DATA_WIDTH:0]     w_sum_fix;
    logic                    w_mag_eq;
    logic                    w_sign_ne;

`ifdef SM_ARB_FIXED_PRIO_EN
    // Fixed priority: scan downward so the lowest valid index is the last hit
    always_comb begin
        w_grant     = '0;
        w_grant_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[ID_W'(i)]) begin
                w_grant     = ID_W'(i);
                w_grant_vld = 1'b1;
            end
        end
    end
`else
    logic [ID_W-1:0] r_ptr;

    // Round-robin: scan offsets downward from the pointer so the nearest wins
    always_comb begin
        int idx;
        idx         = 0;
        w_grant     = '0;
        w_grant_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (req_valid[ID_W'(idx)]) begin
                w_grant     = ID_W'(idx);
                w_grant_vld = 1'b1;
            end
        end
    end

    // Pointer moves to the requester just after the winner on each grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_take) begin
            r_ptr <= (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + ID_W'(1);
        end
    end
`endif

    assign w_take = (r_state == S_IDLE) && w_grant_vld;

    // Accept is only offered to the current winner, and only while idle
    always_comb begin
        w_req_ready = '0;
        if (r_state == S_IDLE && w_grant_vld) begin
            w_req_ready[w_grant] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: fixed walk through the adder pipeline, waiting on the consumer
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_grant_vld) w_next_state = S_ISSUE;
            S_ISSUE:   w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = S_RESP;
            S_RESP:    if (rsp_ready) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Operands and owner ID are latched on the grant and held until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_rsp_id <= '0;
        end else if (w_take) begin
            r_op_a   <= req_a[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH];
            r_op_b   <= req_b[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH];
            r_rsp_id <= w_grant;
        end
    end

    // The adder leaves a stale value for x + (-x), and may produce -0
    assign w_mag_eq  = (r_op_a[DATA_WIDTH-2:0] == r_op_b[DATA_WIDTH-2:0]);
    assign w_sign_ne = (r_op_a[DATA_WIDTH-1] != r_op_b[DATA_WIDTH-1]);

    // Force both problem cases to +0; any zero magnitude is emitted as +0
    always_comb begin
        w_sum_fix = adder_sum;
        if ((w_mag_eq && w_sign_ne) || (adder_sum[DATA_WIDTH-1:0] == '0)) begin
            w_sum_fix = '0;
        end
    end

    // Result is captured in the cycle the adder output is valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_sum <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_rsp_sum <= w_sum_fix;
        end
    end

    assign req_ready = w_req_ready;
    assign adder_a   = r_op_a;
    assign adder_b   = r_op_b;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_sum   = r_rsp_sum;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sm_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm_adder_arbiter
// Description : Self-checking bench for sm_adder_arbiter. Provides a model of
//               the shared registered adder, a directed vector table, hand
//               sequences for back-pressure and mid-operation reset, and
//               randomized requests checked against an arithmetic reference.
//               Honours SM_ARB_FIXED_PRIO_EN for the expected grant order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_adder_arbiter;

    localparam int DW = 4;
    localparam int NR = 4;
    localparam int IW = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NR-1:0]      req_valid = '0;
    logic [NR-1:0]      req_ready;
    logic [NR*DW-1:0]   req_a = '0;
    logic [NR*DW-1:0]   req_b = '0;
    logic [DW-1:0]      adder_a;
    logic [DW-1:0]      adder_b;
    logic [DW:0]        adder_sum = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [DW:0]        rsp_sum;
    logic [IW-1:0]      rsp_id;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    typedef struct {
        int            id;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW:0]   exp;
        int            hold;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    sm_adder_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .adder_a(adder_a), .adder_b(adder_b), .adder_sum(adder_sum),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy)
    );

    // Shared ROM adder: registered, sign-magnitude, keeps its old output on x + (-x)
    always @(posedge clk) begin
        logic [DW-2:0] ma, mb;
        ma = adder_a[DW-2:0];
        mb = adder_b[DW-2:0];
        if (adder_a[DW-1] == adder_b[DW-1])
            adder_sum <= {adder_a[DW-1], DW'(ma) + DW'(mb)};
        else if (ma > mb)
            adder_sum <= {adder_a[DW-1], DW'(ma - mb)};
        else if (mb > ma)
            adder_sum <= {adder_b[DW-1], DW'(mb - ma)};
    end

    // Reference result from plain integer arithmetic
    function automatic logic [DW:0] ref_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int va, vb, s;
        va = a[DW-1] ? -int'(a[DW-2:0]) : int'(a[DW-2:0]);
        vb = b[DW-1] ? -int'(b[DW-2:0]) : int'(b[DW-2:0]);
        s  = va + vb;
        if (s < 0) return {1'b1, DW'(-s)};
        return {1'b0, DW'(s)};
    endfunction

    // Expected winner for a request mask; -1 when nobody asks
    function automatic int model_grant(input logic [NR-1:0] mask);
        if (mask == '0) return -1;
`ifdef SM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NR; i++) if (mask[i]) return i;
`else
        for (int k = 0; k < NR; k++) if (mask[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
`endif
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One full transaction starting at a negedge with the DUT idle; operands
    // must already be on req_a/req_b. Ends at a negedge with the DUT idle.
    task automatic run_op(input logic [NR-1:0] mask, input int hold);
        int            g;
        logic [DW-1:0] ea, eb;
        logic [DW:0]   es;
        req_valid = mask;
        #1;
        g = model_grant(mask);
        chk("grant", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        chk("idle_busy", 32'(busy), 32'd0);
        if (g < 0) begin
            @(negedge clk);
            return;
        end
        ea = req_a[g*DW +: DW];
        eb = req_b[g*DW +: DW];
        es = ref_sum(ea, eb);
        m_ptr = (g + 1) % NR;
        @(negedge clk);                       // ISSUE
        req_valid = '0;
        req_a = NR*DW'($urandom);
        req_b = NR*DW'($urandom);
        #1;
        chk("issue_adder_a", 32'(adder_a), 32'(ea));
        chk("issue_adder_b", 32'(adder_b), 32'(eb));
        chk("issue_busy", 32'(busy), 32'd1);
        chk("issue_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);                       // CAPTURE
        chk("capture_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);                       // RESP
        chk("latency_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_sum", 32'(rsp_sum), 32'(es));
        chk("rsp_id", 32'(rsp_id), 32'(g));
        rsp_ready = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            req_valid = NR'($urandom_range(1, (1 << NR) - 1));
            @(negedge clk);
            #1;
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_sum", 32'(rsp_sum), 32'(es));
            chk("hold_rsp_id", 32'(rsp_id), 32'(g));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);                       // back in IDLE
        chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        // id, a, b, expected sum, cycles of rsp_ready low
        vecs[0] = '{0, 4'b0011, 4'b0010, 5'b00101, 0};   // +3 + +2
        vecs[1] = '{2, 4'b1110, 4'b0010, 5'b10100, 0};   // -6 + +2
        vecs[2] = '{3, 4'b0011, 4'b0100, 5'b00111, 0};   // leaves adder at +7
        vecs[3] = '{1, 4'b0101, 4'b1101, 5'b00000, 0};   // +5 + -5, adder stale
        vecs[4] = '{0, 4'b1000, 4'b1000, 5'b00000, 0};   // -0 + -0
        vecs[5] = '{2, 4'b0111, 4'b0111, 5'b01110, 0};   // largest positive
        vecs[6] = '{3, 4'b1111, 4'b1111, 5'b11110, 5};   // largest negative, back-pressure
        vecs[7] = '{1, 4'b1000, 4'b0000, 5'b00000, 0};   // -0 + +0
        vecs[8] = '{2, 4'b0001, 4'b1100, 5'b10011, 2};   // +1 + -4

        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_adder_a", 32'(adder_a), 32'd0);
        chk("rst_adder_b", 32'(adder_b), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);

        // Directed vectors, one requester at a time
        foreach (vecs[i]) begin
            req_a[vecs[i].id*DW +: DW] = vecs[i].a;
            req_b[vecs[i].id*DW +: DW] = vecs[i].b;
            chk("vec_ref", 32'(ref_sum(vecs[i].a, vecs[i].b)), 32'(vecs[i].exp));
            run_op(NR'(1) << vecs[i].id, vecs[i].hold);
        end

        // All requesters active: rotation (or fixed priority) one grant per 4 cycles
        m_ptr = 0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            req_a = NR*DW'($urandom);
            req_b = NR*DW'($urandom);
            run_op('1, 0);
        end

        // Reset during CAPTURE: outputs clear at once, no response, pointer restarts
        req_a[1*DW +: DW] = 4'b0011;
        req_b[1*DW +: DW] = 4'b0001;
        req_valid = 4'b0010;
        @(negedge clk);                       // ISSUE
        req_valid = '0;
        @(negedge clk);                       // CAPTURE
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_adder_a", 32'(adder_a), 32'd0);
        chk("mid_rst_adder_b", 32'(adder_b), 32'd0);
        chk("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("mid_rst_rsp_sum", 32'(rsp_sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        req_a[1*DW +: DW] = 4'b0110;
        req_b[1*DW +: DW] = 4'b1010;
        req_a[3*DW +: DW] = 4'b0001;
        req_b[3*DW +: DW] = 4'b0001;
        run_op(4'b1010, 0);

        // Randomized traffic against the reference
        for (int n = 0; n < 60; n++) begin
            req_a = NR*DW'($urandom);
            req_b = NR*DW'($urandom);
            run_op(NR'($urandom_range(0, (1 << NR) - 1)), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
